// File: rtl/imm_encode_seq.sv
// ---------------------------------------------------------------------------
// imm_encode_seq
//   Turns a 32-bit constant or a branch target into MIPS I-type instruction
//   words carrying 16-bit immediates, using the shortest sequence possible.
//   Mode 0 loads a constant into rt:
//     - addiu, ori or lui alone when one of them is enough
//     - otherwise the pair lui + ori
//   Mode 1 encodes a PC-relative branch. A target that is not reachable
//   gives one all-zero word with out_err set.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and the payload
// steady until that edge. The consumer may change ready freely.
//
// Parameters
//   USE_ADDIU  nonzero: constants that fit signed 16 bits use addiu
//   PC_INC     byte increment added to in_pc before computing the offset
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (in_ready high only in IDLE)
//   in_mode              0 = load constant, 1 = encode branch
//   in_data              constant (mode 0) or branch target (mode 1)
//   in_pc                byte address of the branch instruction (mode 1)
//   in_op, in_rs         branch opcode and rs field (mode 1)
//   in_rt                destination register / rt field
//   out_valid/out_ready  output word handshake
//   out_instr            encoded instruction word
//   out_last             final word of the current request
//   out_err              request not encodable (out_instr is zero)
//   dbgState             current FSM state (0 IDLE, 1 EMIT1, 2 EMIT2)
// ---------------------------------------------------------------------------
module imm_encode_seq #(
    parameter int          USE_ADDIU = 1,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [31:0] in_data,
    input  logic [31:0] in_pc,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        out_err,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } stateT;

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    stateT       state;
    logic [31:0] secondReg;

    // Combinational classification of the request currently on the inputs.
    // It is only captured on the accepting edge, so the outputs never
    // depend on inputs that change after acceptance.
    logic        fitsSigned16;
    logic [31:0] branchOff;
    logic        branchOk;
    logic [31:0] firstWord;
    logic [31:0] secondWord;
    logic        firstLast;
    logic        reqErr;

    always_comb begin
        // Upper 17 bits all ones or all zeros: addiu's sign extension
        // rebuilds the whole constant.
        fitsSigned16 = (&in_data[31:15]) || ~(|in_data[31:15]);
        branchOff    = in_data - (in_pc + PC_INC);
        // Word aligned and the signed word offset fits 16 bits, i.e. the
        // byte offset sign-extends cleanly from bit 17.
        branchOk     = (branchOff[1:0] == 2'b00) &&
                       (branchOff[31:17] == {15{branchOff[17]}});

        firstWord  = 32'd0;
        secondWord = 32'd0;
        firstLast  = 1'b1;
        reqErr     = 1'b0;

        if (!in_mode) begin
            if ((USE_ADDIU != 0) && fitsSigned16) begin
                firstWord = {OP_ADDIU, 5'd0, in_rt, in_data[15:0]};
            end else if (in_data[31:16] == 16'd0) begin
                firstWord = {OP_ORI, 5'd0, in_rt, in_data[15:0]};
            end else if (in_data[15:0] == 16'd0) begin
                firstWord = {OP_LUI, 5'd0, in_rt, in_data[31:16]};
            end else begin
                firstWord  = {OP_LUI, 5'd0, in_rt, in_data[31:16]};
                secondWord = {OP_ORI, in_rt, in_rt, in_data[15:0]};
                firstLast  = 1'b0;
            end
        end else if (branchOk) begin
            firstWord = {in_op, in_rs, in_rt, branchOff[17:2]};
        end else begin
            reqErr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            secondReg <= 32'd0;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= EMIT1;
                        out_valid <= 1'b1;
                        out_instr <= firstWord;
                        out_last  <= firstLast;
                        out_err   <= reqErr;
                        secondReg <= secondWord;
                    end
                end
                EMIT1: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= EMIT2;
                            out_instr <= secondReg;
                            out_last  <= 1'b1;
                        end
                    end
                end
                EMIT2: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign dbgState = state;

endmodule
